// File: rtl/arb_mux2x1_if.sv
// Handshake bundle for the 2:1 round-robin mux: two valid/ready sources in, one registered stream out.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives and consumes it.
interface arb_mux2x1_if #(
    parameter int WIDTH = 8
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_sel;
    logic             y_ready;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, y_ready,
        output a_ready, b_ready, y_valid, y_data, y_sel
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, y_ready,
        input  a_ready, b_ready, y_valid, y_data, y_sel
    );
endinterface

// File: rtl/arb_mux2x1.sv
// Round-robin 2:1 mux into a single output register; one clock from input transfer to y_valid/y_data.
// Readies drop whenever the held word is not being taken (y_valid & !y_ready), so upstream stalls in place.
module arb_mux2x1 #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    arb_mux2x1_if.slave   bus
);
    logic             y_valid_q, y_valid_d;
    logic [WIDTH-1:0] y_data_q,  y_data_d;
    logic             y_sel_q,   y_sel_d;
    logic             last_grant_q, last_grant_d;
    logic             load_en;
    logic             grant_a, grant_b;

    assign load_en = !y_valid_q || bus.y_ready;

    // last_grant_q = 1 means B won most recently, so A has priority on the next contention.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n && load_en) begin
            if (bus.a_valid && bus.b_valid) begin
                if (last_grant_q) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else if (bus.a_valid) begin
                grant_a = 1'b1;
            end else if (bus.b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    always_comb begin
        y_valid_d    = y_valid_q;
        y_data_d     = y_data_q;
        y_sel_d      = y_sel_q;
        last_grant_d = last_grant_q;
        if (grant_a) begin
            y_valid_d    = 1'b1;
            y_data_d     = bus.a_data;
            y_sel_d      = 1'b0;
            last_grant_d = 1'b0;
        end else if (grant_b) begin
            y_valid_d    = 1'b1;
            y_data_d     = bus.b_data;
            y_sel_d      = 1'b1;
            last_grant_d = 1'b1;
        end else if (bus.y_ready) begin
            y_valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid_q    <= 1'b0;
            y_data_q     <= '0;
            y_sel_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            y_valid_q    <= y_valid_d;
            y_data_q     <= y_data_d;
            y_sel_q      <= y_sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.a_ready = grant_a;
    assign bus.b_ready = grant_b;
    assign bus.y_valid = y_valid_q;
    assign bus.y_data  = y_data_q;
    assign bus.y_sel   = y_sel_q;
endmodule

// File: tb/tb_arb_mux2x1.sv
// Bench for arb_mux2x1: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a word-level reference model and an in-order scoreboard.
module tb_arb_mux2x1;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    arb_mux2x1_if #(.WIDTH(W)) bus ();

    arb_mux2x1 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: what the output register holds, who won last, and words granted but not yet consumed.
    logic         m_vld;
    logic [W-1:0] m_data;
    logic         m_sel;
    logic         m_last;
    logic [W:0]   pend_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {b_granted, a_granted} from the arbitration rules.
    function automatic logic [1:0] pick(input logic rst_ok, input logic out_full, input logic yr,
                                        input logic av, input logic bv, input logic last);
        logic can_load;
        can_load = rst_ok && (!out_full || yr);
        if (!can_load)      return 2'b00;
        if (av && bv)       return last ? 2'b01 : 2'b10;
        if (av)             return 2'b01;
        if (bv)             return 2'b10;
        return 2'b00;
    endfunction

    initial begin
        logic [1:0] g;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_vld  = 1'b0;
                m_data = '0;
                m_sel  = 1'b0;
                m_last = 1'b1;
                pend_q.delete();
            end else begin
                g = pick(1'b1, m_vld, bus.y_ready, bus.a_valid, bus.b_valid, m_last);
                if (g != 2'b00) begin
                    m_vld  = 1'b1;
                    m_sel  = g[1];
                    m_data = g[1] ? bus.b_data : bus.a_data;
                    m_last = g[1];
                    pend_q.push_back({m_sel, m_data});
                end else if (bus.y_ready) begin
                    m_vld = 1'b0;
                end
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    initial begin
        logic [1:0] g;
        logic [W:0] w;
        forever begin
            @(negedge clk);
            g = pick(rst_n, m_vld, bus.y_ready, bus.a_valid, bus.b_valid, m_last);
            check("a_ready", 32'(bus.a_ready), 32'(g[0]));
            check("b_ready", 32'(bus.b_ready), 32'(g[1]));
            check("y_valid", 32'(bus.y_valid), 32'(m_vld));
            check("y_data",  32'(bus.y_data),  32'(m_data));
            check("y_sel",   32'(bus.y_sel),   32'(m_sel));
            if (rst_n && bus.y_valid === 1'b1 && bus.y_ready) begin
                if (pend_q.size() == 0) begin
                    check("scoreboard_underflow", 32'(pend_q.size()), 32'd1);
                end else begin
                    w = pend_q.pop_front();
                    check("scoreboard_order", 32'({bus.y_sel, bus.y_data}), 32'(w));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic av, input logic [W-1:0] ad, input logic bv,
                         input logic [W-1:0] bd, input logic yr);
        bus.a_valid = av;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_data  = bd;
        bus.y_ready = yr;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        drive(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
        #1 rst_n = 1'b0;

        // Reset with random inputs, then idle after release.
        @(negedge clk);
        drive(1'b1, 8'hA7, 1'b1, 8'h5E, 1'b1);
        #1;
        check("rst_y_valid", 32'(bus.y_valid), 32'd0);
        check("rst_y_data",  32'(bus.y_data),  32'h00);
        check("rst_y_sel",   32'(bus.y_sel),   32'd0);
        check("rst_a_ready", 32'(bus.a_ready), 32'd0);
        check("rst_b_ready", 32'(bus.b_ready), 32'd0);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        step();
        step();
        @(negedge clk);
        check("idle_y_valid", 32'(bus.y_valid), 32'd0);

        // Single source A.
        step();
        drive(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("single_a_ready", 32'(bus.a_ready), 32'd1);
        check("single_b_ready", 32'(bus.b_ready), 32'd0);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("single_y_valid", 32'(bus.y_valid), 32'd1);
        check("single_y_data",  32'(bus.y_data),  32'h3C);
        check("single_y_sel",   32'(bus.y_sel),   32'd0);

        // Hand priority back to A with a lone B word, then contend for 4 cycles.
        step();
        drive(1'b0, 8'h00, 1'b1, 8'h77, 1'b1);
        step();
        drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            if (i == 3) drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
            @(negedge clk);
            check("rr_y_valid", 32'(bus.y_valid), 32'd1);
            check("rr_y_sel",   32'(bus.y_sel),   32'(i % 2));
            check("rr_y_data",  32'(bus.y_data),  (i % 2 == 0) ? 32'h11 : 32'h22);
        end

        // Back-pressure: hold 0x55 for 3 cycles with both sources waiting.
        step();
        drive(1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
        step();
        drive(1'b1, 8'h66, 1'b1, 8'h99, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_a_ready", 32'(bus.a_ready), 32'd0);
            check("bp_b_ready", 32'(bus.b_ready), 32'd0);
            check("bp_y_data",  32'(bus.y_data),  32'h55);
            check("bp_y_valid", 32'(bus.y_valid), 32'd1);
            if (i < 2) step();
        end
        step();
        drive(1'b1, 8'h66, 1'b1, 8'h99, 1'b1);
        @(negedge clk);
        check("bp_release_b_ready", 32'(bus.b_ready), 32'd1);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("bp_next_y_data", 32'(bus.y_data), 32'h99);
        check("bp_next_y_sel",  32'(bus.y_sel),  32'd1);

        // Priority retention across idle cycles.
        step();
        drive(1'b0, 8'h00, 1'b1, 8'h44, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();
        step();
        drive(1'b1, 8'hA1, 1'b1, 8'hB2, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("retain_y_sel",  32'(bus.y_sel),  32'd0);
        check("retain_y_data", 32'(bus.y_data), 32'hA1);

        // Reset pulse between edges while a word is held.
        step();
        @(negedge clk);
        check("midrst_pre_y_valid", 32'(bus.y_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_y_valid", 32'(bus.y_valid), 32'd0);
        check("midrst_y_data",  32'(bus.y_data),  32'h00);
        #1 rst_n = 1'b1;
        step();
        drive(1'b1, 8'h13, 1'b1, 8'h24, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("midrst_first_sel",  32'(bus.y_sel),  32'd0);
        check("midrst_first_data", 32'(bus.y_data), 32'h13);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            step();
            drive(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) != 0));
        end
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();
        step();
        @(negedge clk);
        check("drain_pending", 32'(pend_q.size()), 32'd0);
        check("drain_y_valid", 32'(bus.y_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
